vending_credit_fsm: RTL and testbench



---
 rtl/vending_pkg.sv | 44 ++++
 rtl/coin_sync_edge.sv | 37 +++
 rtl/vending_credit_fsm.sv | 124 ++++++++++++
 tb/tb_vending_credit_fsm.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared definitions for the tomato vending machine: state codes, coin values
// and price, plus small helpers used by the credit FSM and the decode stage.
package vending_pkg;

    // State codes presented on S: 0..4 = credit in quarters, 5..8 = dispense
    localparam logic [3:0] S0 = 4'd0;
    localparam logic [3:0] S1 = 4'd1;
    localparam logic [3:0] S2 = 4'd2;
    localparam logic [3:0] S3 = 4'd3;
    localparam logic [3:0] S4 = 4'd4;
    localparam logic [3:0] S5 = 4'd5;
    localparam logic [3:0] S6 = 4'd6;
    localparam logic [3:0] S7 = 4'd7;
    localparam logic [3:0] S8 = 4'd8;

    // Coin values in quarter units
    localparam logic [3:0] Q_VAL = 4'd1;
    localparam logic [3:0] H_VAL = 4'd2;
    localparam logic [3:0] D_VAL = 4'd4;

    // Item price in quarter units ($1.25)
    localparam logic [3:0] PRICE = 4'd5;

    typedef enum logic {
        IDLE_CREDIT = 1'b0,
        DISPENSE    = 1'b1
    } vend_state_e;

    // Value of a single coin event; zero when no coin is flagged
    function automatic logic [3:0] coin_value(input logic q, input logic h, input logic d);
        logic [3:0] v;
        v = 4'd0;
        if (q) v = Q_VAL;
        if (h) v = H_VAL;
        if (d) v = D_VAL;
        return v;
    endfunction

    // Only codes 0..8 are meaningful on S
    function automatic logic is_legal_code(input logic [3:0] s);
        return (s <= S8);
    endfunction

endpackage

// File: rtl/coin_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector for one raw coin
// input. Produces a single-cycle event per insertion however long the coin
// line stays high.
module coin_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic coin_in,
    output logic evt
);

    logic sync1_q, sync2_q, sync3_q;
    logic sync1_d, sync2_d, sync3_d;

    // Shift the raw input down the synchroniser / edge-detect chain
    always_comb begin
        sync1_d = coin_in;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
    end

    // Chain clears on reset so a line held high through reset release
    // still yields exactly one event afterwards
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
        end
    end

    assign evt = sync2_q & ~sync3_q;

endmodule

// File: rtl/vending_credit_fsm.sv
// Credit-accumulating FSM for the tomato vending machine. Turns synchronised
// coin events into the 4-bit state code S and holds dispense codes for
// HOLD_CYCLES clocks before returning to zero credit.
module vending_credit_fsm
    import vending_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       quarter,
    input  logic       half,
    input  logic       dollar,
    output logic [3:0] S,
    output logic       coin_reject
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic q_evt, h_evt, d_evt;
    logic any_evt, multi_evt;
    logic [3:0] coin_val;
    logic [3:0] credit_sum;

    vend_state_e      state_q, state_d;
    logic [3:0]       s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rej_q, rej_d;

    coin_sync_edge u_sync_quarter (
        .clk     (clk),
        .reset   (reset),
        .coin_in (quarter),
        .evt     (q_evt)
    );

    coin_sync_edge u_sync_half (
        .clk     (clk),
        .reset   (reset),
        .coin_in (half),
        .evt     (h_evt)
    );

    coin_sync_edge u_sync_dollar (
        .clk     (clk),
        .reset   (reset),
        .coin_in (dollar),
        .evt     (d_evt)
    );

    assign any_evt   = q_evt | h_evt | d_evt;
    assign multi_evt = (q_evt & h_evt) | (q_evt & d_evt) | (h_evt & d_evt);
    assign coin_val  = coin_value(q_evt, h_evt, d_evt);

    // Next-state, credit, hold-count and reject computation
    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        cnt_d      = cnt_q;
        rej_d      = 1'b0;
        credit_sum = s_q + coin_val;

        if (!is_legal_code(s_q)) begin
            // Recover from a corrupted code by dropping to zero credit
            state_d = IDLE_CREDIT;
            s_d     = S0;
            cnt_d   = '0;
            rej_d   = any_evt;
        end else begin
            case (state_q)
                IDLE_CREDIT: begin
                    if (multi_evt) begin
                        // Ambiguous simultaneous coins: keep credit, flag it
                        rej_d = 1'b1;
                    end else if (any_evt) begin
                        // Credit is at most 4 here, so the sum tops out at 8
                        s_d = credit_sum;
                        if (credit_sum >= PRICE) begin
                            state_d = DISPENSE;
                            cnt_d   = '0;
                        end
                    end
                end
                DISPENSE: begin
                    // Coins are never credited while dispensing, including
                    // the cycle in which the machine returns to zero
                    rej_d = any_evt;
                    if (cnt_q == HOLD_LAST) begin
                        state_d = IDLE_CREDIT;
                        s_d     = S0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE_CREDIT;
                    s_d     = S0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, credit code, hold counter and registered reject pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE_CREDIT;
            s_q     <= S0;
            cnt_q   <= '0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            rej_q   <= rej_d;
        end
    end

    assign S           = s_q;
    assign coin_reject = rej_q;

endmodule

// File: tb/tb_vending_credit_fsm.sv
// Directed bench for vending_credit_fsm with HOLD_CYCLES = 4.
module tb_vending_credit_fsm;

    localparam int HOLD = 4;
    localparam logic [2:0] QM = 3'b001;
    localparam logic [2:0] HM = 3'b010;
    localparam logic [2:0] DM = 3'b100;

    logic       clk;
    logic       reset;
    logic       quarter, half, dollar;
    logic [3:0] s_out;
    logic       coin_reject;

    int checks;
    int errors;

    vending_credit_fsm #(.HOLD_CYCLES(HOLD)) dut (
        .clk         (clk),
        .reset       (reset),
        .quarter     (quarter),
        .half        (half),
        .dollar      (dollar),
        .S           (s_out),
        .coin_reject (coin_reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input integer got, input integer exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Starting at a negedge: raise the coins in mask for one cycle, then
    // check S just after the 2nd edge (unchanged) and after the 3rd edge.
    task automatic pulse(input logic [2:0] mask, input int exp_pre,
                         input int exp_post, input int exp_rej, input string tag);
        {dollar, half, quarter} = mask;
        @(negedge clk);
        {dollar, half, quarter} = 3'b000;
        @(negedge clk);
        check({tag, "_pre"}, s_out, exp_pre);
        @(negedge clk);
        check({tag, "_S"}, s_out, exp_post);
        check({tag, "_rej"}, coin_reject, exp_rej);
    endtask

    // At the negedge after the edge where a dispense code appeared:
    // S must hold for HOLD-1 more edges and be 0 at the HOLD-th.
    task automatic hold_check(input int code, input string tag);
        for (int i = 1; i < HOLD; i++) begin
            @(negedge clk);
            check({tag, "_hold"}, s_out, code);
        end
        @(negedge clk);
        check({tag, "_end"}, s_out, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        {dollar, half, quarter} = 3'b000;
        reset = 1'b1;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_S", s_out, 0);
            check("rst_rej", coin_reject, 0);
        end
        reset = 1'b0;

        // Five single quarters: 1,2,3,4 then dispense at 5
        pulse(QM, 0, 1, 0, "q1");
        pulse(QM, 1, 2, 0, "q2");
        pulse(QM, 2, 3, 0, "q3");
        pulse(QM, 3, 4, 0, "q4");
        pulse(QM, 4, 5, 0, "q5");
        check("chg5", int'(s_out) - 5, 0);
        hold_check(5, "d5");

        // Quarter, quarter, dollar -> 6, then a dollar while dispensing
        pulse(QM, 0, 1, 0, "qqd_q1");
        pulse(QM, 1, 2, 0, "qqd_q2");
        pulse(DM, 2, 6, 0, "qqd_d");
        check("chg6", int'(s_out) - 5, 1);
        pulse(DM, 6, 6, 1, "d6_rej");
        @(negedge clk);
        check("d6_end", s_out, 0);
        check("d6_rej_clr", coin_reject, 0);

        // Simultaneous coins at S=1 are rejected, then a half -> 3
        pulse(QM, 0, 1, 0, "m_q");
        pulse(QM | HM, 1, 1, 1, "multi");
        @(negedge clk);
        check("multi_rej_clr", coin_reject, 0);
        check("multi_S", s_out, 1);
        pulse(HM, 1, 3, 0, "m_h");
        pulse(QM, 3, 4, 0, "m_q2");
        pulse(DM, 4, 8, 0, "d8");
        check("chg8", int'(s_out) - 5, 3);
        @(negedge clk);
        check("d8_h1", s_out, 8);
        // Coin landing on the return-to-zero edge is still rejected
        pulse(QM, 8, 0, 1, "d8_edge_rej");
        @(negedge clk);
        check("d8_after", s_out, 0);

        // Half held for 20 cycles counts once
        begin
            int rej_seen;
            rej_seen = 0;
            half = 1'b1;
            @(negedge clk);
            @(negedge clk);
            check("hold_pre", s_out, 0);
            for (int i = 0; i < 18; i++) begin
                @(negedge clk);
                if (coin_reject) rej_seen++;
            end
            half = 1'b0;
            check("hold_S", s_out, 2);
            check("hold_rej", rej_seen, 0);
            repeat (3) @(negedge clk);
            check("hold_S2", s_out, 2);
        end

        // Asynchronous mid-cycle reset with quarter held across release
        #2;
        reset = 1'b1;
        quarter = 1'b1;
        #1;
        check("arst_S", s_out, 0);
        check("arst_rej", coin_reject, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arst_hold", s_out, 0);
        end
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rel_pre", s_out, 0);
        @(negedge clk);
        check("rel_S", s_out, 1);
        repeat (10) @(negedge clk);
        check("rel_once", s_out, 1);
        quarter = 1'b0;
        @(negedge clk);

        // Reset in the middle of a dispense leaves no residual hold count
        pulse(DM, 1, 5, 0, "rd_d");
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rd_S", s_out, 0);
        @(negedge clk);
        reset = 1'b0;
        pulse(QM, 0, 1, 0, "rd_q");
        pulse(DM, 1, 5, 0, "rd_d2");
        hold_check(5, "rd5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
